// File: rtl/dffsr_q_debounce.sv
// Debounce stage for the q output of the negedge set/clear flop.
// The raw level is resynchronised into the posedge clk domain.
// A new level must hold for STABLE_CYCLES consecutive samples before dout follows it.
// Each dout transition produces a one-cycle rise or fall pulse.
// Qualified rises are counted in a saturating counter that has a sticky saturation flag.
module dffsr_q_debounce #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             din,
    input  logic             en,
    input  logic             clear_cnt,
    output logic             dout,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] rise_cnt,
    output logic             sat
);

    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
    localparam logic [STAB_W-1:0] STAB_ZERO = STAB_W'(0);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   din_s;
    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [STAB_W-1:0]      stab_r;
    logic [STAB_W-1:0]      stab_nxt_s;
    logic                   dout_r;
    logic                   dout_nxt_s;
    logic                   rise_r;
    logic                   rise_nxt_s;
    logic                   fall_r;
    logic                   fall_nxt_s;
    logic [CNT_W-1:0]       rise_cnt_r;
    logic                   sat_r;

    assign din_s = sync_r[SYNC_STAGES-1];

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
        end
    end

    // Next-state logic: a candidate level is qualified once stab reaches STABLE_CYCLES-1 while it still holds.
    always_comb begin
        state_nxt_s = state_r;
        stab_nxt_s  = stab_r;
        rise_nxt_s  = 1'b0;
        fall_nxt_s  = 1'b0;
        case (state_r)
            ST_LOW: begin
                if (din_s) begin
                    state_nxt_s = ST_WAIT_HIGH;
                    stab_nxt_s  = STAB_ONE;
                end else begin
                    state_nxt_s = ST_LOW;
                end
            end
            ST_WAIT_HIGH: begin
                if (!din_s) begin
                    state_nxt_s = ST_LOW;
                    stab_nxt_s  = STAB_ZERO;
                end else if (stab_r == STAB_LAST) begin
                    state_nxt_s = ST_HIGH;
                    stab_nxt_s  = STAB_ZERO;
                    rise_nxt_s  = 1'b1;
                end else begin
                    stab_nxt_s  = stab_r + STAB_ONE;
                end
            end
            ST_HIGH: begin
                if (!din_s) begin
                    state_nxt_s = ST_WAIT_LOW;
                    stab_nxt_s  = STAB_ONE;
                end else begin
                    state_nxt_s = ST_HIGH;
                end
            end
            ST_WAIT_LOW: begin
                if (din_s) begin
                    state_nxt_s = ST_HIGH;
                    stab_nxt_s  = STAB_ZERO;
                end else if (stab_r == STAB_LAST) begin
                    state_nxt_s = ST_LOW;
                    stab_nxt_s  = STAB_ZERO;
                    fall_nxt_s  = 1'b1;
                end else begin
                    stab_nxt_s  = stab_r + STAB_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_LOW;
                stab_nxt_s  = STAB_ZERO;
            end
        endcase
        dout_nxt_s = (state_nxt_s == ST_HIGH) || (state_nxt_s == ST_WAIT_LOW);
    end

    // Register the FSM state, the stability counter and the level/pulse outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r <= ST_LOW;
            stab_r  <= STAB_ZERO;
            dout_r  <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            stab_r  <= stab_nxt_s;
            dout_r  <= dout_nxt_s;
            rise_r  <= rise_nxt_s;
            fall_r  <= fall_nxt_s;
        end
    end

    // Rise counter: clear wins, and the count steps on the same edge that raises the rise pulse.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rise_cnt_r <= {CNT_W{1'b0}};
            sat_r      <= 1'b0;
        end else if (clear_cnt) begin
            rise_cnt_r <= {CNT_W{1'b0}};
            sat_r      <= 1'b0;
        end else if (rise_nxt_s && en) begin
            if (rise_cnt_r != CNT_MAX) begin
                rise_cnt_r <= rise_cnt_r + CNT_W'(1);
            end else begin
                sat_r      <= 1'b1;
            end
        end else begin
            rise_cnt_r <= rise_cnt_r;
        end
    end

    assign dout     = dout_r;
    assign rise     = rise_r;
    assign fall     = fall_r;
    assign rise_cnt = rise_cnt_r;
    assign sat      = sat_r;

endmodule

// File: tb/tb_dffsr_q_debounce.sv
// Self-checking bench for dffsr_q_debounce.
// The reference model works from a sliding window: dout flips once the last STABLE_CYCLES
// synchronised samples all disagree with it. The synchronised sample is din delayed by SYNC_STAGES edges.
module tb_dffsr_q_debounce;

    localparam int SS = 2;
    localparam int SC = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          clr;
    logic          din;
    logic          en;
    logic          clear_cnt;
    logic          dout;
    logic          rise;
    logic          fall;
    logic [CW-1:0] rise_cnt;
    logic          sat;

    int total = 0;
    int bad   = 0;

    bit hist[SS];
    bit win[SC];
    bit m_dout, m_rise, m_fall, m_sat;
    int m_cnt;

    dffsr_q_debounce #(.SYNC_STAGES(SS), .STABLE_CYCLES(SC), .CNT_W(CW)) dut (
        .clk(clk), .clr(clr), .din(din), .en(en), .clear_cnt(clear_cnt),
        .dout(dout), .rise(rise), .fall(fall), .rise_cnt(rise_cnt), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        foreach (hist[i]) hist[i] = 1'b0;
        foreach (win[i]) win[i] = 1'b0;
        m_dout = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_sat = 1'b0; m_cnt = 0;
    endtask

    task automatic model_edge();
        bit s;
        bit flip;
        s = hist[SS-1];
        for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = din;
        for (int i = SC - 1; i > 0; i--) win[i] = win[i-1];
        win[0] = s;
        flip = 1'b1;
        for (int i = 0; i < SC; i++) if (win[i] == m_dout) flip = 1'b0;
        m_rise = flip && !m_dout;
        m_fall = flip && m_dout;
        if (flip) m_dout = !m_dout;
        if (clear_cnt) begin
            m_cnt = 0; m_sat = 1'b0;
        end else if (m_rise && en) begin
            if (m_cnt < (1 << CW) - 1) m_cnt++;
            else m_sat = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b0; din = 1'b0; en = 1'b1; clear_cnt = 1'b0;
        model_reset();
        #3;
        total++;
        if ({dout, rise, fall, rise_cnt, sat} !== {1'b0, 1'b0, 1'b0, {CW{1'b0}}, 1'b0}) begin
            bad++; $display("FAIL reset_async: got %b%b%b cnt=%0d sat=%b want all zero", dout, rise, fall, rise_cnt, sat);
        end
        @(negedge clk);
        clr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if ({dout, rise, fall, rise_cnt, sat} !== {1'b0, 1'b0, 1'b0, {CW{1'b0}}, 1'b0}) begin
                bad++; $display("FAIL reset_idle c%0d: got %b%b%b cnt=%0d sat=%b want all zero", i, dout, rise, fall, rise_cnt, sat);
            end
        end
    endtask

    task automatic test_basic();
        din = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            total++;
            if ({dout, rise, fall, rise_cnt} !== {(e >= 5) ? 1'b1 : 1'b0, (e == 5) ? 1'b1 : 1'b0, 1'b0, (e >= 5) ? CW'(1) : CW'(0)}) begin
                bad++; $display("FAIL basic_rise e%0d: got dout=%b rise=%b fall=%b cnt=%0d want rise at edge 5", e, dout, rise, fall, rise_cnt);
            end
        end
        din = 1'b0;
        for (int e = 0; e < 8; e++) begin
            tick();
            total++;
            if ({dout, rise, fall, rise_cnt} !== {(e >= 5) ? 1'b0 : 1'b1, 1'b0, (e == 5) ? 1'b1 : 1'b0, CW'(1)}) begin
                bad++; $display("FAIL basic_fall e%0d: got dout=%b rise=%b fall=%b cnt=%0d want fall at edge 5", e, dout, rise, fall, rise_cnt);
            end
        end
    endtask

    task automatic test_glitch();
        int nr;
        int nf;
        din = 1'b1;
        repeat (3) tick();
        din = 1'b0;
        for (int e = 0; e < 10; e++) begin
            tick();
            total++;
            if ({dout, rise, fall, rise_cnt} !== {1'b0, 1'b0, 1'b0, CW'(1)}) begin
                bad++; $display("FAIL glitch3 e%0d: got dout=%b rise=%b fall=%b cnt=%0d want no change", e, dout, rise, fall, rise_cnt);
            end
        end
        nr = 0; nf = 0;
        din = 1'b1;
        for (int e = 0; e < 16; e++) begin
            tick();
            if (e == 4) din = 1'b0;
            nr += rise; nf += fall;
            total++;
            if ({dout, rise, fall, rise_cnt, sat} !== {m_dout, m_rise, m_fall, m_cnt[CW-1:0], m_sat}) begin
                bad++; $display("FAIL glitch4 e%0d: got %b%b%b cnt=%0d sat=%b want %b%b%b cnt=%0d sat=%b", e, dout, rise, fall, rise_cnt, sat, m_dout, m_rise, m_fall, m_cnt, m_sat);
            end
        end
        total++;
        if (nr != 1 || nf != 1) begin
            bad++; $display("FAIL glitch4_pulses: got rises=%0d falls=%0d want 1 and 1", nr, nf);
        end
    endtask

    task automatic test_saturate();
        clear_cnt = 1'b1; tick(); clear_cnt = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            for (int ph = 0; ph < 2; ph++) begin
                din = (ph == 0);
                for (int e = 0; e < 7; e++) begin
                    tick();
                    total++;
                    if ({dout, rise, fall, rise_cnt, sat} !== {m_dout, m_rise, m_fall, m_cnt[CW-1:0], m_sat}) begin
                        bad++; $display("FAIL sat_seq k%0d e%0d: got %b%b%b cnt=%0d sat=%b want %b%b%b cnt=%0d sat=%b", k, e, dout, rise, fall, rise_cnt, sat, m_dout, m_rise, m_fall, m_cnt, m_sat);
                    end
                end
                if (ph == 0) begin
                    total++;
                    if (rise_cnt !== CW'((k < 7) ? k : 7) || sat !== (k >= 8)) begin
                        bad++; $display("FAIL sat_count k%0d: got cnt=%0d sat=%b want cnt=%0d sat=%b", k, rise_cnt, sat, (k < 7) ? k : 7, k >= 8);
                    end
                end
            end
        end
        din = 1'b1;
        repeat (5) tick();
        clear_cnt = 1'b1;
        tick();
        clear_cnt = 1'b0;
        total++;
        if ({rise, rise_cnt, sat} !== {1'b1, CW'(0), 1'b0}) begin
            bad++; $display("FAIL clear_on_rise: got rise=%b cnt=%0d sat=%b want rise=1 cnt=0 sat=0", rise, rise_cnt, sat);
        end
        din = 1'b0;
        repeat (7) tick();
    endtask

    task automatic test_en_off();
        int nr;
        nr = 0;
        en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            din = 1'b1; for (int e = 0; e < 7; e++) begin tick(); nr += rise; end
            din = 1'b0; for (int e = 0; e < 7; e++) begin tick(); nr += rise; end
        end
        total++;
        if (nr != 2 || rise_cnt !== CW'(0) || dout !== 1'b0) begin
            bad++; $display("FAIL en_off: got rises=%0d cnt=%0d dout=%b want 2 rises cnt=0 dout=0", nr, rise_cnt, dout);
        end
        en = 1'b1;
        din = 1'b1;
        repeat (7) tick();
        total++;
        if (rise_cnt !== CW'(1) || dout !== 1'b1) begin
            bad++; $display("FAIL en_on: got cnt=%0d dout=%b want cnt=1 dout=1", rise_cnt, dout);
        end
        din = 1'b0;
        repeat (7) tick();
    endtask

    task automatic test_reset_mid();
        din = 1'b1;
        repeat (4) tick();
        #2;
        clr = 1'b0;
        #1;
        model_reset();
        total++;
        if ({dout, rise, fall, rise_cnt, sat} !== {1'b0, 1'b0, 1'b0, {CW{1'b0}}, 1'b0}) begin
            bad++; $display("FAIL reset_mid: got %b%b%b cnt=%0d sat=%b want all zero", dout, rise, fall, rise_cnt, sat);
        end
        @(negedge clk);
        clr = 1'b1;
        for (int e = 0; e < 7; e++) begin
            tick();
            total++;
            if ({dout, rise, fall, rise_cnt} !== {(e >= 5) ? 1'b1 : 1'b0, (e == 5) ? 1'b1 : 1'b0, 1'b0, (e >= 5) ? CW'(1) : CW'(0)}) begin
                bad++; $display("FAIL reset_release e%0d: got dout=%b rise=%b fall=%b cnt=%0d want rise at edge 5", e, dout, rise, fall, rise_cnt);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int i = 0; i < 400; i++) begin
            if (hold == 0) begin
                din  = $urandom_range(0, 1);
                hold = $urandom_range(1, 7);
            end
            hold--;
            en        = ($urandom_range(0, 3) != 0);
            clear_cnt = ($urandom_range(0, 40) == 0);
            tick();
            total++;
            if ({dout, rise, fall, rise_cnt, sat} !== {m_dout, m_rise, m_fall, m_cnt[CW-1:0], m_sat}) begin
                bad++; $display("FAIL random c%0d: got %b%b%b cnt=%0d sat=%b want %b%b%b cnt=%0d sat=%b", i, dout, rise, fall, rise_cnt, sat, m_dout, m_rise, m_fall, m_cnt, m_sat);
            end
        end
        clear_cnt = 1'b0;
        en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_saturate();
        test_en_off();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
